// File: rtl/lfsr_period_monitor.sv
// Measures the recurrence period of an LFSR state stream, counted in valid samples.
// Reports period, maximal-length, lock-up and timeout flags once per measurement.
module lfsr_period_monitor #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] state_in,
  input  logic             state_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] period,
  output logic             max_len,
  output logic             stuck,
  output logic             timeout
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARM     = 2'd1;
  localparam logic [1:0] S_MEASURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX        = '1;
  localparam logic [31:0]      MAX_LEN_PERIOD = 32'((64'd1 << WIDTH) - 64'd1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             max_len_q, max_len_d;
  logic             stuck_q, stuck_d;
  logic             timeout_q, timeout_d;

  logic [CNT_W-1:0] count_inc;
  logic             is_match;

  // The counter saturates rather than wrapping; the timeout exit fires at the ceiling anyway.
  assign count_inc = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);
  // Gating on state_valid keeps an undriven state_in from reaching the compare.
  assign is_match  = state_valid && (state_in == ref_q);

  always_comb begin
    state_d   = state_q;
    ref_d     = ref_q;
    count_d   = count_q;
    period_d  = period_q;
    max_len_d = max_len_q;
    stuck_d   = stuck_q;
    timeout_d = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_ARM;
          period_d  = '0;
          max_len_d = 1'b0;
          stuck_d   = 1'b0;
          timeout_d = 1'b0;
        end
      end
      S_ARM: begin
        if (state_valid) begin
          ref_d   = state_in;
          count_d = '0;
          state_d = S_MEASURE;
        end
      end
      S_MEASURE: begin
        if (state_valid) begin
          count_d = count_inc;
          // A match on the last countable sample still counts as a valid period.
          if (is_match) begin
            period_d  = count_inc;
            max_len_d = (32'(count_inc) == MAX_LEN_PERIOD);
            stuck_d   = (count_inc == CNT_W'(1));
            timeout_d = 1'b0;
            state_d   = S_DONE;
          end else if (count_inc == CNT_MAX) begin
            period_d  = '0;
            max_len_d = 1'b0;
            stuck_d   = 1'b0;
            timeout_d = 1'b1;
            state_d   = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ref_q     <= '0;
      count_q   <= '0;
      period_q  <= '0;
      max_len_q <= 1'b0;
      stuck_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ref_q     <= ref_d;
      count_q   <= count_d;
      period_q  <= period_d;
      max_len_q <= max_len_d;
      stuck_q   <= stuck_d;
      timeout_q <= timeout_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign period  = period_q;
  assign max_len = max_len_q;
  assign stuck   = stuck_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_lfsr_period_monitor.sv
// Randomized scoreboard bench for lfsr_period_monitor: expected results come from
// a recurrence search over the sample stream fed to the DUT.
module tb_lfsr_period_monitor;

  typedef struct packed {
    logic [7:0] period;
    logic       max_len;
    logic       stuck;
    logic       timeout;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] state_in;
  logic       state_valid;
  logic       busy;
  logic       done;
  logic [7:0] period;
  logic       max_len;
  logic       stuck;
  logic       timeout;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  exp_t last_exp;
  logic [3:0] stim_q[$];
  logic prev_done = 1'b0;

  lfsr_period_monitor #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .state_in(state_in),
    .state_valid(state_valid), .busy(busy), .done(done), .period(period),
    .max_len(max_len), .stuck(stuck), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got no response, expected a done pulse", name);
  endtask

  // Reference: period is the distance to the first recurrence of the first sample, capped at 255.
  function automatic exp_t modelPeriod();
    exp_t e;
    int p = 0;
    for (int i = 1; i < stim_q.size() && i <= 255; i++) begin
      if (stim_q[i] == stim_q[0]) begin
        p = i;
        break;
      end
    end
    e.period  = 8'(p);
    e.timeout = (p == 0);
    e.max_len = (p == 15);
    e.stuck   = (p == 1);
    return e;
  endfunction

  task automatic buildLfsr(input logic [3:0] seed);
    logic [3:0] s = seed;
    stim_q.delete();
    for (int i = 0; i < 300; i++) begin
      stim_q.push_back(s);
      s = {s[2:0], s[3] ^ s[2]};
    end
  endtask

  task automatic buildConst(input logic [3:0] v);
    stim_q.delete();
    for (int i = 0; i < 300; i++) stim_q.push_back(v);
  endtask

  task automatic buildRecurAt(input int k);
    logic [3:0] v;
    stim_q.delete();
    stim_q.push_back(4'd5);
    for (int i = 1; i < 300; i++) begin
      v = 4'($urandom_range(0, 15));
      if (v == 4'd5) v = 4'd6;
      stim_q.push_back((i == k) ? 4'd5 : v);
    end
  endtask

  task automatic buildPattern(input int len);
    logic [3:0] pat[$];
    stim_q.delete();
    for (int i = 0; i < len; i++) pat.push_back(4'($urandom_range(0, 15)));
    for (int i = 0; i < 300; i++) stim_q.push_back(pat[i % len]);
  endtask

  // gap_div>0: valid every gap_div cycles; 0: random valid. restart_at/abort_at are sample indices.
  task automatic applyStimulus(input int gap_div, input int restart_at, input int abort_at, input string tag);
    exp_t e;
    int   idx = 0;
    int   cyc = 0;
    bit   seen = 0;
    bit   busy_bad = 0;
    bit   aborted = 0;
    bit   v;
    e = modelPeriod();
    if (abort_at == 0) begin
      exp_q.push_back(e);
      last_exp = e;
    end
    @(negedge clk);
    start = 1'b1;
    state_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (!seen && !aborted && cyc < 3000) begin
      v = (gap_div > 0) ? ((cyc % gap_div) == 0) : ($urandom_range(0, 2) != 0);
      start = 1'b0;
      if (v && idx < stim_q.size()) begin
        state_valid = 1'b1;
        state_in = stim_q[idx];
        idx++;
        if (restart_at > 0 && idx == restart_at) start = 1'b1;
      end else begin
        state_valid = 1'b0;
        state_in = 'x;
      end
      @(negedge clk);
      cyc++;
      if (done === 1'b1) seen = 1;
      else if (busy !== 1'b1) busy_bad = 1;
      if (!seen && abort_at > 0 && idx >= abort_at) begin
        #2 rst = 1'b0;
        #1;
        checkOutput({"abort_busy_", tag}, 32'(busy), 0);
        checkOutput({"abort_done_", tag}, 32'(done), 0);
        checkOutput({"abort_period_", tag}, 32'(period), 0);
        checkOutput({"abort_flags_", tag}, {29'd0, max_len, stuck, timeout}, 0);
        aborted = 1;
      end
    end
    start = 1'b0;
    state_valid = 1'b0;
    state_in = 'x;
    checkOutput({"busy_during_", tag}, 32'(busy_bad), 0);
    if (aborted) begin
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput({"idle_after_abort_", tag}, 32'(busy), 0);
    end else if (!seen) begin
      failNow({"wait_done_", tag});
      exp_q.delete();
    end else begin
      checkOutput({"busy_at_done_", tag}, 32'(busy), 1);
      @(negedge clk);
      checkOutput({"busy_idle_", tag}, 32'(busy), 0);
    end
  endtask

  // Monitor: pops one expectation per done pulse, independent of the stimulus process.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && done === 1'b1) begin
      if (prev_done) checkOutput("done_width", 32'(prev_done), 0);
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", 32'(done), 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("period", 32'(period), 32'(e.period));
        checkOutput("max_len", 32'(max_len), 32'(e.max_len));
        checkOutput("stuck", 32'(stuck), 32'(e.stuck));
        checkOutput("timeout", 32'(timeout), 32'(e.timeout));
      end
    end
    prev_done <= (rst === 1'b1) && (done === 1'b1);
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int kind;
    rst = 1'b0;
    start = 1'b0;
    state_valid = 1'b0;
    state_in = 4'd0;
    #100;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_done", 32'(done), 0);
    checkOutput("reset_period", 32'(period), 0);
    checkOutput("reset_flags", {29'd0, max_len, stuck, timeout}, 0);

    buildLfsr(4'b1111);
    applyStimulus(1, 0, 0, "maxlen");
    buildConst(4'b0000);
    applyStimulus(1, 0, 0, "lockup");
    buildLfsr(4'b1111);
    applyStimulus(3, 0, 0, "gaps");
    stim_q.delete();
    stim_q.push_back(4'd1);
    stim_q.push_back(4'd2);
    for (int i = 2; i < 300; i++) stim_q.push_back(4'd3);
    applyStimulus(1, 0, 0, "timeout");
    buildRecurAt(255);
    applyStimulus(1, 0, 0, "match_at_255");
    buildRecurAt(256);
    applyStimulus(1, 0, 0, "match_at_256");
    buildLfsr(4'b1111);
    applyStimulus(1, 0, 7, "abort");
    applyStimulus(1, 0, 0, "after_abort");
    applyStimulus(1, 5, 0, "restart_ignored");

    repeat (5) @(negedge clk);
    checkOutput("hold_period", 32'(period), 32'(last_exp.period));
    checkOutput("hold_max_len", 32'(max_len), 32'(last_exp.max_len));
    #3 rst = 1'b0;
    #1 checkOutput("async_reset_period", 32'(period), 0);
    checkOutput("async_reset_max_len", 32'(max_len), 0);
    @(negedge clk);
    rst = 1'b1;

    for (int r = 0; r < 12; r++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: buildLfsr(4'($urandom_range(0, 15)));
        1: buildPattern($urandom_range(1, 20));
        2: buildRecurAt($urandom_range(1, 270));
        default: buildRecurAt(400);
      endcase
      applyStimulus(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3), 0, 0, $sformatf("rand%0d", r));
    end

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
